// File: rtl/vjtag_pkg.sv
// Package shared by the VJTAG1 data-register engine and its helpers.
// Purpose: virtual instruction codes, the ir_out signature and the
//          instruction decode helper used to pick bypass vs. data path.
// Ports:   none (package).
package vjtag_pkg;

    localparam logic [3:0] IR_BYPASS   = 4'h0;
    localparam logic [3:0] IR_WR_DATA  = 4'h1;
    localparam logic [3:0] IR_RD_DATA  = 4'h2;
    localparam logic [3:0] IR_SET_ADDR = 4'h3;
    localparam logic [3:0] IR_STATUS   = 4'h4;
    localparam logic [3:0] IR_CLR_ERR  = 4'hF;

    // Fixed low bits of ir_out so the host can recognise this node on an IR scan.
    localparam logic [2:0] IR_OUT_SIG = 3'b101;

    // Only the four data instructions use the DW-bit register; every other code,
    // including CLR_ERR (which acts on UIR, not on a DR scan), takes the 1-bit bypass path.
    function automatic logic ir_is_bypass(input logic [3:0] ir);
        return !((ir == IR_WR_DATA) || (ir == IR_RD_DATA) ||
                 (ir == IR_SET_ADDR) || (ir == IR_STATUS));
    endfunction

endpackage

// File: rtl/vjtag_dr_engine_if.sv
// User-side register bus produced by the VJTAG1 data-register engine.
// Purpose: groups the write strobe/address/data, the read address/data and
//          the status word into one bundle.
// Ports (signals):
//   wr_en    1   one-tck write strobe (engine -> user)
//   wr_addr  AW  write address, valid while wr_en = 1 (engine -> user)
//   wr_data  DW  write data, valid while wr_en = 1 (engine -> user)
//   rd_addr  AW  read address, always driven (engine -> user)
//   rd_data  DW  read data for rd_addr (user -> engine)
//   status   DW  user status word (user -> engine)
// Modports: master = engine side, slave = user register side.
interface vjtag_dr_engine_if #(
    parameter int DW = 8,
    parameter int AW = 4
) ();

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] status;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data,
        input  status
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data,
        output status
    );

endinterface

// File: rtl/vjtag_shreg.sv
// Capture/shift data register with a saturating bit counter.
// Purpose: holds the DW-bit DR, loads it on capture, shifts it LSB-first
//          and counts the shifted bits so the top level can tell a full
//          scan from a short or long one.
// Ports:
//   clk       in   1   tck
//   rst       in   1   synchronous active-high reset
//   capture   in   1   capture-DR: clears the counter, loads when load_en
//   load_en   in   1   load load_val on capture (non-bypass instruction)
//   load_val  in   DW  value captured into the register
//   shift     in   1   shift one bit (ignored while capture is high)
//   tdi       in   1   serial input, enters at the MSB
//   sr        out  DW  register contents; sr[0] is the serial output
//   cnt       out  CW  shifted-bit count, saturates at DW+1
module vjtag_shreg #(
    parameter int DW = 8,
    parameter int CW = $clog2(DW + 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          capture,
    input  logic          load_en,
    input  logic [DW-1:0] load_val,
    input  logic          shift,
    input  logic          tdi,
    output logic [DW-1:0] sr,
    output logic [CW-1:0] cnt
);

    // DW+1 is enough to distinguish "too long" from "exactly DW" without wrapping.
    localparam logic [CW-1:0] CNT_MAX = CW'(DW + 1);

    logic [DW-1:0] sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Capture has priority over shift so a simultaneous CDR/SDR never shifts.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (capture) begin
            cnt_d = '0;
            if (load_en) begin
                sr_d = load_val;
            end
        end else if (shift) begin
            sr_d = {tdi, sr_q[DW-1:1]};
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign sr  = sr_q;
    assign cnt = cnt_q;

endmodule

// File: rtl/vjtag_dr_engine.sv
// VJTAG1 data-register engine, tck domain.
// Purpose: decodes the virtual IR, runs capture/shift/update of the DR and
//          turns host scans into addressed writes, reads and status reads.
//          A wrong-length scan is dropped and flagged in ir_out[3].
// Ports:
//   tck                 in   1   JTAG clock, the only clock
//   rst                 in   1   synchronous active-high reset
//   tdi / tdo           in/out   serial data from / to VJTAG1
//   ir_in               in   4   current virtual instruction
//   ir_out              out  4   {err, 3'b101}, read back on an IR scan
//   virtual_state_*     in   1   TAP state flags; only cdr, sdr, udr, uir act
//   user                master   user register bus (vjtag_dr_engine_if)
module vjtag_dr_engine
    import vjtag_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic                 tck,
    input  logic                 rst,
    input  logic                 tdi,
    output logic                 tdo,
    input  logic [3:0]           ir_in,
    output logic [3:0]           ir_out,
    input  logic                 virtual_state_cdr,
    input  logic                 virtual_state_sdr,
    input  logic                 virtual_state_e1dr,
    input  logic                 virtual_state_pdr,
    input  logic                 virtual_state_e2dr,
    input  logic                 virtual_state_udr,
    input  logic                 virtual_state_cir,
    input  logic                 virtual_state_uir,
    vjtag_dr_engine_if.master    user
);

    localparam int CW = $clog2(DW + 2);

    // TAP states that carry no action for this node.
    logic unused_states;
    assign unused_states = &{1'b0, virtual_state_e1dr, virtual_state_pdr,
                             virtual_state_e2dr, virtual_state_cir};

    logic          bypass;
    logic [DW-1:0] cap_val;
    logic [DW-1:0] sr;
    logic [CW-1:0] cnt;
    logic          scan_ok;
    logic          udr_act;

    logic          bp_q, bp_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          err_q, err_d;
    logic          udr_q;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;

    assign bypass  = ir_is_bypass(ir_in);
    assign scan_ok = (cnt == CW'(DW));

    // Update acts on the first cycle of UDR only, so wr_en can never
    // be asserted twice in a row even if udr were held.
    assign udr_act = virtual_state_udr && !udr_q;

    // Capture source for the data instructions; WR_DATA starts from zero.
    always_comb begin
        case (ir_in)
            IR_RD_DATA:  cap_val = user.rd_data;
            IR_STATUS:   cap_val = user.status;
            IR_SET_ADDR: cap_val = DW'(addr_q);
            default:     cap_val = '0;
        endcase
    end

    vjtag_shreg #(
        .DW (DW),
        .CW (CW)
    ) u_shreg (
        .clk      (tck),
        .rst      (rst),
        .capture  (virtual_state_cdr),
        .load_en  (!bypass),
        .load_val (cap_val),
        .shift    (virtual_state_sdr && !bypass),
        .tdi      (tdi),
        .sr       (sr),
        .cnt      (cnt)
    );

    // Bypass bit, address pointer, sticky error and the write strobe.
    always_comb begin
        bp_d      = bp_q;
        addr_d    = addr_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (bypass) begin
            if (virtual_state_cdr) begin
                bp_d = 1'b0;
            end else if (virtual_state_sdr) begin
                bp_d = tdi;
            end
        end

        if (virtual_state_uir && (ir_in == IR_CLR_ERR)) begin
            err_d = 1'b0;
        end

        if (udr_act && !bypass) begin
            if (scan_ok) begin
                case (ir_in)
                    IR_WR_DATA: begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = sr;
                        addr_d    = addr_q + 1'b1;
                    end
                    IR_RD_DATA:  addr_d = addr_q + 1'b1;
                    IR_SET_ADDR: addr_d = sr[AW-1:0];
                    default:     addr_d = addr_q;
                endcase
            end else begin
                // Placed after the clear so a same-cycle set wins.
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge tck) begin
        if (rst) begin
            bp_q      <= 1'b0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            udr_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            bp_q      <= bp_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            udr_q     <= virtual_state_udr;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign tdo          = bypass ? bp_q : sr[0];
    assign ir_out       = {err_q, IR_OUT_SIG};
    assign user.wr_en   = wr_en_q;
    assign user.wr_addr = wr_addr_q;
    assign user.wr_data = wr_data_q;
    assign user.rd_addr = addr_q;

endmodule

// File: tb/tb_vjtag_dr_engine.sv
// Self-checking bench for vjtag_dr_engine: directed scans from the block's
// test list followed by randomized scans against a scan-level reference model.
module tb_vjtag_dr_engine;

    localparam int DW = 8;
    localparam int AW = 4;

    logic       tck = 1'b0;
    logic       rst;
    logic       tdi;
    logic       tdo;
    logic [3:0] ir_in;
    logic [3:0] ir_out;
    logic       cdr, sdr, e1dr, pdr, e2dr, udr, cir, uir;

    vjtag_dr_engine_if #(.DW(DW), .AW(AW)) user ();

    vjtag_dr_engine #(.DW(DW), .AW(AW)) dut (
        .tck                (tck),
        .rst                (rst),
        .tdi                (tdi),
        .tdo                (tdo),
        .ir_in              (ir_in),
        .ir_out             (ir_out),
        .virtual_state_cdr  (cdr),
        .virtual_state_sdr  (sdr),
        .virtual_state_e1dr (e1dr),
        .virtual_state_pdr  (pdr),
        .virtual_state_e2dr (e2dr),
        .virtual_state_udr  (udr),
        .virtual_state_cir  (cir),
        .virtual_state_uir  (uir),
        .user               (user)
    );

    always #5 tck = ~tck;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state: address pointer, sticky error, read memory.
    int        mAddr;
    bit        mErr;
    bit [7:0]  rdMem [16];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic bit isDataIr(input logic [3:0] code);
        return (code >= 4'h1) && (code <= 4'h4);
    endfunction

    // IR update with the given code; CLR_ERR clears the error seen in ir_out.
    task automatic loadIr(input logic [3:0] code);
        @(negedge tck);
        ir_in = code;
        uir   = 1'b1;
        @(negedge tck);
        uir = 1'b0;
        if (code == 4'hF) mErr = 1'b0;
        checkOutput("ir_out_after_uir", 32'(ir_out), 32'({mErr, 3'b101}));
    endtask

    // One complete DR scan: capture, nbits of shift, exit1, update.
    // The tdo stream is predicted as "captured word LSB first, then the bits
    // the host pushed in", or "0 then tdi delayed by one" for bypass.
    task automatic applyStimulus(input logic [3:0] code, input logic [15:0] data,
                                 input int nbits, input bit overlap);
        logic [7:0] cap;
        logic [7:0] st;
        logic       expBit;
        bit         expWr;
        int         expWrAddr;
        logic [7:0] expWrData;

        @(negedge tck);
        ir_in        = code;
        st           = 8'($urandom);
        user.rd_data = rdMem[mAddr];
        user.status  = st;
        case (code)
            4'h2:    cap = rdMem[mAddr];
            4'h4:    cap = st;
            4'h3:    cap = 8'(mAddr);
            default: cap = 8'h00;
        endcase
        cdr = 1'b1;
        if (overlap) begin
            sdr = 1'b1;
            tdi = 1'b1;
        end
        for (int i = 0; i < nbits; i++) begin
            @(negedge tck);
            cdr = 1'b0;
            sdr = 1'b1;
            tdi = data[i];
            #1;
            if (!isDataIr(code)) expBit = (i == 0) ? 1'b0 : data[i-1];
            else                 expBit = (i < DW) ? cap[i] : data[i-DW];
            checkOutput($sformatf("tdo_ir%0h_bit%0d", code, i), 32'(tdo), 32'(expBit));
        end
        @(negedge tck);
        cdr  = 1'b0;
        sdr  = 1'b0;
        tdi  = 1'b0;
        e1dr = 1'b1;
        @(negedge tck);
        e1dr = 1'b0;
        udr  = 1'b1;
        @(negedge tck);
        udr = 1'b0;

        expWr     = 1'b0;
        expWrAddr = 0;
        expWrData = 8'h00;
        if (isDataIr(code)) begin
            if (nbits == DW) begin
                case (code)
                    4'h1: begin
                        expWr     = 1'b1;
                        expWrAddr = mAddr;
                        expWrData = data[7:0];
                        mAddr     = (mAddr + 1) % 16;
                    end
                    4'h2:    mAddr = (mAddr + 1) % 16;
                    4'h3:    mAddr = int'(data[3:0]);
                    default: ;
                endcase
            end else begin
                mErr = 1'b1;
            end
        end

        checkOutput("wr_en_after_udr", 32'(user.wr_en), 32'(expWr));
        if (expWr) begin
            checkOutput("wr_addr", 32'(user.wr_addr), 32'(expWrAddr));
            checkOutput("wr_data", 32'(user.wr_data), 32'(expWrData));
        end
        checkOutput("rd_addr", 32'(user.rd_addr), 32'(mAddr));
        checkOutput("ir_out", 32'(ir_out), 32'({mErr, 3'b101}));
        @(negedge tck);
        checkOutput("wr_en_single_cycle", 32'(user.wr_en), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        tdi = 1'b0; ir_in = 4'h0;
        cdr = 1'b0; sdr = 1'b0; e1dr = 1'b0; pdr = 1'b0;
        e2dr = 1'b0; udr = 1'b0; cir = 1'b0; uir = 1'b0;
        user.rd_data = '0;
        user.status  = '0;
        for (int i = 0; i < 16; i++) rdMem[i] = 8'($urandom);
        rdMem[5] = 8'hA5;
        mAddr = 0;
        mErr  = 1'b0;

        repeat (3) @(negedge tck);
        rst = 1'b0;
        checkOutput("reset_ir_out", 32'(ir_out), 32'h5);
        checkOutput("reset_wr_en", 32'(user.wr_en), 32'd0);
        checkOutput("reset_wr_addr", 32'(user.wr_addr), 32'd0);
        checkOutput("reset_wr_data", 32'(user.wr_data), 32'd0);
        checkOutput("reset_rd_addr", 32'(user.rd_addr), 32'd0);
        checkOutput("reset_tdo_bypass", 32'(tdo), 32'd0);
        ir_in = 4'h1;
        #1;
        checkOutput("reset_tdo_sr", 32'(tdo), 32'd0);

        // Set address 5, read 0xA5 out, write 0x3C at 5.
        loadIr(4'h3);
        applyStimulus(4'h3, 16'h0005, 8, 1'b0);
        loadIr(4'h2);
        applyStimulus(4'h2, 16'h0000, 8, 1'b0);
        applyStimulus(4'h3, 16'h0005, 8, 1'b0);
        applyStimulus(4'h1, 16'h003C, 8, 1'b0);

        // Address wrap on write.
        applyStimulus(4'h3, 16'h000F, 8, 1'b0);
        applyStimulus(4'h1, 16'h0077, 8, 1'b0);

        // Short scan sets the error; CLR_ERR on UIR clears it.
        applyStimulus(4'h1, 16'h0055, 7, 1'b0);
        loadIr(4'hF);

        // Bypass on 0x0 and on an unassigned code.
        applyStimulus(4'h0, 16'h0005, 3, 1'b0);
        applyStimulus(4'h9, 16'h0005, 3, 1'b0);

        // Capture and shift together: capture wins.
        applyStimulus(4'h3, 16'h00A3, 8, 1'b1);

        // Reset in the middle of a write scan, with the error set beforehand.
        applyStimulus(4'h2, 16'h0000, 9, 1'b0);
        @(negedge tck);
        ir_in = 4'h1;
        cdr   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge tck);
            cdr = 1'b0;
            sdr = 1'b1;
            tdi = 1'b1;
        end
        @(negedge tck);
        sdr = 1'b0;
        rst = 1'b1;
        @(negedge tck);
        rst = 1'b0;
        mAddr = 0;
        mErr  = 1'b0;
        checkOutput("abort_wr_en", 32'(user.wr_en), 32'd0);
        checkOutput("abort_rd_addr", 32'(user.rd_addr), 32'd0);
        checkOutput("abort_ir_out", 32'(ir_out), 32'h5);
        checkOutput("abort_tdo", 32'(tdo), 32'd0);
        applyStimulus(4'h1, 16'h0011, 8, 1'b0);

        // Randomized scans.
        for (int n = 0; n < 60; n++) begin
            logic [3:0] code;
            int         pick;
            int         nb;
            pick = $urandom_range(0, 6);
            if (pick <= 4)      code = 4'(pick);
            else                code = 4'($urandom_range(5, 14));
            nb = 8;
            if ($urandom_range(0, 3) == 0) nb = ($urandom_range(0, 1) == 0) ? 7 : 9;
            applyStimulus(code, 16'($urandom), nb, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 4) == 0) loadIr(4'hF);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
